// File: rtl/pixel_stream_pkg.sv
// Shared types and default timing for the pixel-stream transmitter.
// Default geometry is a 28x28 frame, 16-bit pixels, 10 stored frames.
package pixel_stream_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_LINE_PIXELS = 28;
    localparam int DEF_LINES       = 28;
    localparam int DEF_V_FRONT     = 5;
    localparam int DEF_H_BLANK     = 4;
    localparam int DEF_V_BACK      = 3;
    localparam int DEF_MAX_FRAMES  = 10;

    localparam int FRAME_PIXELS = DEF_LINES * DEF_LINE_PIXELS;

    typedef enum logic [2:0] {
        IDLE,
        VFRONT,
        ACTIVE,
        HBLANK,
        VBACK,
        FINISH
    } stream_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pixel_stream_source_timing.sv
// Frame/line timing generator: state, porch/column/line counters and sync pulses.
// Also reports one cycle ahead whether the next cycle is a memory prefetch slot.
module stream_timing_gen
    import pixel_stream_pkg::*;
#(
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int LINES       = DEF_LINES,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_BACK      = DEF_V_BACK,
    localparam int CW = $clog2(LINE_PIXELS),
    localparam int LW = $clog2(LINES),
    localparam int PW = $clog2(max3(V_FRONT, H_BLANK, V_BACK) + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          go_empty,
    input  logic          last_frame,
    output stream_state_e state,
    output logic [CW-1:0] col_idx,
    output logic [LW-1:0] line_idx,
    output logic          frame_start,
    output logic          prefetch_next,
    output logic          hsync,
    output logic          vsync
);

    stream_state_e state_q, state_d;
    logic [PW-1:0] porch_q, porch_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] line_q, line_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;

    always_comb begin
        state_d = state_q;
        porch_d = porch_q;
        col_d   = col_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = VFRONT;
                    porch_d = '0;
                end else if (go_empty) begin
                    state_d = FINISH;
                end
            end
            VFRONT: begin
                if (porch_q == PW'(V_FRONT - 1)) begin
                    state_d = ACTIVE;
                    col_d   = '0;
                    line_d  = '0;
                end else begin
                    porch_d = porch_q + PW'(1);
                end
            end
            ACTIVE: begin
                if (col_q == CW'(LINE_PIXELS - 1)) begin
                    state_d = HBLANK;
                    porch_d = '0;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            HBLANK: begin
                if (porch_q == PW'(H_BLANK - 1)) begin
                    porch_d = '0;
                    if (line_q == LW'(LINES - 1)) begin
                        state_d = VBACK;
                    end else begin
                        state_d = ACTIVE;
                        col_d   = '0;
                        line_d  = line_q + LW'(1);
                    end
                end else begin
                    porch_d = porch_q + PW'(1);
                end
            end
            VBACK: begin
                if (porch_q == PW'(V_BACK - 1)) begin
                    porch_d = '0;
                    state_d = last_frame ? FINISH : VFRONT;
                end else begin
                    porch_d = porch_q + PW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A prefetch slot is any cycle whose successor is an ACTIVE cycle.
    always_comb begin
        prefetch_next = ((state_d == VFRONT) && (porch_d == PW'(V_FRONT - 1)))
                     || ((state_d == HBLANK) && (porch_d == PW'(H_BLANK - 1))
                         && (line_d != LW'(LINES - 1)))
                     || ((state_d == ACTIVE) && (col_d != CW'(LINE_PIXELS - 1)));
        frame_start   = (state_d == VFRONT) && (state_q != VFRONT);
        hsync_d       = (state_q == ACTIVE);
        vsync_d       = (state_q == VFRONT) || (state_q == ACTIVE) || (state_q == HBLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            porch_q <= '0;
            col_q   <= '0;
            line_q  <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            porch_q <= porch_d;
            col_q   <= col_d;
            line_q  <= line_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign state    = state_q;
    assign col_idx  = col_q;
    assign line_idx = line_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;

endmodule

// File: rtl/pixel_stream_source.sv
// Replays stored frames from a synchronous frame memory as a VSYNC/HSYNC pixel stream.
// Define PIXEL_TEST_PATTERN_EN to replace memory reads with a generated frame/offset pattern.
module pixel_stream_source
    import pixel_stream_pkg::*;
#(
    parameter int dataWidth   = DEF_DATA_WIDTH,
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int LINES       = DEF_LINES,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_BACK      = DEF_V_BACK,
    parameter int MAX_FRAMES  = DEF_MAX_FRAMES,
    parameter int AW          = $clog2(MAX_FRAMES * LINES * LINE_PIXELS),
    localparam int FW = $clog2(MAX_FRAMES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [FW-1:0]        frame_first,
    input  logic [7:0]           frame_count,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_en,
    output logic [AW-1:0]        mem_addr,
    input  logic [dataWidth-1:0] mem_rdata,
    output logic [dataWidth-1:0] pix,
    output logic                 HSYNC,
    output logic                 VSYNC
);

    localparam int CW         = $clog2(LINE_PIXELS);
    localparam int LW         = $clog2(LINES);
    localparam int FRAME_SIZE = LINES * LINE_PIXELS;

    stream_state_e state;
    logic [CW-1:0] col_idx;
    logic [LW-1:0] line_idx;
    logic          frame_start;
    logic          prefetch_next;
    logic          accept, go, go_empty, last_frame;

    logic [FW-1:0]        frame_idx_q, frame_idx_d;
    logic [7:0]           frames_left_q, frames_left_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mem_en_q, mem_en_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [dataWidth-1:0] pix_q, pix_d;

    assign accept     = start && (state == IDLE);
    assign go         = accept && (frame_count != 8'd0);
    assign go_empty   = accept && (frame_count == 8'd0);
    assign last_frame = (frames_left_q == 8'd1);

    stream_timing_gen #(
        .LINE_PIXELS (LINE_PIXELS),
        .LINES       (LINES),
        .V_FRONT     (V_FRONT),
        .H_BLANK     (H_BLANK),
        .V_BACK      (V_BACK)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .go_empty      (go_empty),
        .last_frame    (last_frame),
        .state         (state),
        .col_idx       (col_idx),
        .line_idx      (line_idx),
        .frame_start   (frame_start),
        .prefetch_next (prefetch_next),
        .hsync         (HSYNC),
        .vsync         (VSYNC)
    );

    // Frame sequencing: the index advances (with wrap) only on VBACK -> VFRONT.
    always_comb begin
        frame_idx_d   = frame_idx_q;
        frames_left_d = frames_left_q;
        if (accept) begin
            frame_idx_d   = frame_first;
            frames_left_d = frame_count;
        end else if (frame_start && (state == VBACK)) begin
            frame_idx_d   = (frame_idx_q == FW'(MAX_FRAMES - 1)) ? '0 : frame_idx_q + FW'(1);
            frames_left_d = frames_left_q - 8'd1;
        end
    end

    // Reads within a frame are strictly sequential, so the address is a
    // counter reloaded with the frame base and bumped after every read.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (frame_start) begin
            mem_addr_d = AW'(frame_idx_d) * AW'(FRAME_SIZE);
        end else if (mem_en_q) begin
            mem_addr_d = mem_addr_q + AW'(1);
        end
    end

`ifdef PIXEL_TEST_PATTERN_EN
    logic [15:0] pat_word;
    logic        unused_rdata;

    assign pat_word     = {4'(frame_idx_q), 12'(int'(line_idx) * LINE_PIXELS + int'(col_idx))};
    assign unused_rdata = ^mem_rdata;

    always_comb begin
        mem_en_d = 1'b0;
        pix_d    = '0;
        if (state == ACTIVE) begin
            pix_d = dataWidth'(pat_word);
        end
    end
`else
    logic unused_pos;

    assign unused_pos = ^{col_idx, line_idx};

    // Read data arrives during the ACTIVE cycle and is registered onto pix,
    // so pix lines up with the registered HSYNC.
    always_comb begin
        mem_en_d = prefetch_next;
        pix_d    = '0;
        if (state == ACTIVE) begin
            pix_d = mem_rdata;
        end
    end
`endif

    always_comb begin
        busy_d = accept
              || (state == VFRONT) || (state == ACTIVE)
              || (state == HBLANK) || (state == VBACK);
        done_d = (state == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_idx_q   <= '0;
            frames_left_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            pix_q         <= '0;
        end else begin
            frame_idx_q   <= frame_idx_d;
            frames_left_q <= frames_left_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            pix_q         <= pix_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign pix      = pix_q;

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Transmit end of the VSYNC/HSYNC pixel-stream interface consumed by stream_neural_net.
- Reads stored 28x28 frames from a synchronous frame memory.
- Replays them as a timed stream: 16-bit pixel per cycle, with HSYNC marking active pixels and VSYNC marking each frame.
- Sits between the image/batch memory and the network input, replacing bench-driven stimulus on hardware.

Parameters:
- dataWidth, 16, pixel width in bits.
- LINE_PIXELS, 28, active pixels per line.
- LINES, 28, lines per frame.
- V_FRONT, 5, cycles VSYNC high before first line.
- H_BLANK, 4, HSYNC-low cycles after every line, including the last.
- V_BACK, 3, VSYNC-low cycles after each frame.
- MAX_FRAMES, 10, frames held in memory.
- AW, $clog2(MAX_FRAMES*LINES*LINE_PIXELS), memory address width.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset, asynchronous assert, active low.
- start, in, 1, one-cycle request; honoured only in IDLE.
- frame_first, in, $clog2(MAX_FRAMES), first frame index, latched on start.
- frame_count, in, 8, number of frames to stream, latched on start.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse after last frame's V_BACK.
- mem_en, out, 1, frame-memory read enable.
- mem_addr, out, AW, frame-memory read address.
- mem_rdata, in, dataWidth, read data, valid one cycle after mem_en.
- pix, out, dataWidth, streamed pixel.
- HSYNC, out, 1, high during the LINE_PIXELS active cycles of a line.
- VSYNC, out, 1, high from frame start through last line's H_BLANK.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mem_en, HSYNC, VSYNC = 0; pix = 0; mem_addr = 0; counters cleared. Reset mid-frame aborts immediately, with no done pulse.
- All outputs are registered.
- States:
  - IDLE -> VFRONT on start. If latched frame_count=0, go IDLE -> FINISH instead; no VSYNC is emitted and done pulses the next cycle.
  - VFRONT: V_FRONT cycles, VSYNC=1, HSYNC=0 -> ACTIVE.
  - ACTIVE: LINE_PIXELS cycles, VSYNC=1, HSYNC=1, pix = memory word -> HBLANK.
  - HBLANK: H_BLANK cycles, VSYNC=1, HSYNC=0. Then -> ACTIVE if lines remain, else -> VBACK.
  - VBACK: V_BACK cycles, VSYNC=0. Then -> VFRONT if frames remain (frame index +1, wraps MAX_FRAMES-1 -> 0), else -> FINISH.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Frame period = V_FRONT + LINES*(LINE_PIXELS+H_BLANK) + V_BACK = 904 cycles at defaults.
- Pixel addressing: pixel (line l, column x) of frame f reads mem_addr = f*LINES*LINE_PIXELS + l*LINE_PIXELS + x.
- Memory prefetch:
  - mem_en=1 with the address in the cycle before each ACTIVE cycle, i.e. the last VFRONT/HBLANK cycle and ACTIVE cycles except the last of a line.
  - pix registers mem_rdata, so the first HSYNC cycle of a line carries x=0.
- pix = 0 whenever HSYNC=0.
- start while busy is ignored. frame_first and frame_count are sampled only on the accepting cycle.
- VSYNC falls on the same edge VBACK is entered. Back-to-back frames give a V_BACK-cycle low gap, then VSYNC rises again.

Optional Feature:
- Macro PIXEL_TEST_PATTERN_EN.
- Defined: mem_en held 0; pix during ACTIVE = {frame_idx[3:0], 12'(l*LINE_PIXELS+x)} truncated to dataWidth, for memoryless link bring-up. Timing is unchanged.
- Undefined: pixels come from memory as above.

Decomposition:
- Package pixel_stream_pkg holds: the state enum (IDLE, VFRONT, ACTIVE, HBLANK, VBACK, FINISH), the default timing constants, and the frame-size constant LINES*LINE_PIXELS.
- One sub-module, stream_timing_gen, generates state, column/line/porch counters and the HSYNC/VSYNC pulses.
- The top level adds start/done handshake, frame sequencing, address generation and the pixel register.

Test Plan:
- Reset idle: rst_n=0 then 1, no start -> HSYNC=VSYNC=busy=done=mem_en=0, pix=0 for 100 cycles.
- Single frame: frame_first=2, frame_count=1, memory word k = k -> VSYNC high 901 cycles. 28 HSYNC bursts of 28 cycles, each followed by 4 low cycles. Burst 0 pix = 1568..1595, burst 27 ends at 2351. done pulses 904 cycles after VSYNC rises.
- Multi-frame wrap: frame_first=9, frame_count=3 -> frames 9, 0, 1 streamed. VSYNC low exactly 3 cycles between frames. done after 2712 cycles.
- Zero count: frame_count=0 -> VSYNC never rises; done pulse the cycle after busy rises.
- Busy start / mid-op reset: start re-asserted mid-frame -> ignored, frame count unchanged. rst_n=0 during line 10 -> all outputs 0 asynchronously, no done. Restart works normally.
- PIXEL_TEST_PATTERN_EN defined: frame_first=3 -> mem_en never 1, first pixel 0x3000, last pixel of frame 0x330F.
